// File: rtl/jpeg_pkg.sv
// Shared JPEG encoder definitions: packer FSM states, marker/stuff bytes and
// the longest Huffman code length.
package jpeg_pkg;

    localparam int MAX_CODE_LEN = 16;

    localparam logic [7:0] MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] EOI_CODE      = 8'hD9;
    localparam logic [7:0] STUFF_BYTE    = 8'h00;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_STUFF,
        ST_PAD,
        ST_DRAIN,
        ST_EOI_FF,
        ST_EOI_D9,
        ST_DONE
    } packer_state_t;

    // Number of one-bits needed to bring a bit count up to a byte boundary.
    function automatic logic [2:0] pad_count(input logic [2:0] cnt_lsb);
        return 3'd0 - cnt_lsb;
    endfunction

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// Output byte register for the bit packer: valid/ready hold, and a 0x00
// inserted after every non-marker 0xFF byte.
module jpeg_byte_stuffer
    import jpeg_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load_req,
    input  logic [7:0] load_data,
    input  logic       load_marker,
    output logic       load_ack,
    output logic       stuff_set,
    output logic       stuff_pend,
    output logic       idle,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_marker
);

    logic can_take;

    assign can_take  = !out_valid || out_ready;
    assign load_ack  = load_req && can_take && !stuff_pend;
    assign stuff_set = load_ack && !load_marker && (load_data == MARKER_PREFIX);
    assign idle      = !out_valid && !stuff_pend;

    // A pending stuff byte has priority over any new accumulator byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_marker <= 1'b0;
            stuff_pend <= 1'b0;
        end else if (stuff_pend && can_take) begin
            out_valid  <= 1'b1;
            out_data   <= STUFF_BYTE;
            out_marker <= 1'b0;
            stuff_pend <= 1'b0;
        end else if (load_ack) begin
            out_valid  <= 1'b1;
            out_data   <= load_data;
            out_marker <= load_marker;
            stuff_pend <= stuff_set;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/jpeg_bit_packer.sv
// Packs variable-length Huffman codes MSB-first into a stuffed byte stream.
// Optional EOI marker emission on flush: define JPEG_PACKER_EOI_EN.
module jpeg_bit_packer
    import jpeg_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int MAX_LEN = MAX_CODE_LEN,
    parameter int LEN_W   = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAX_LEN-1:0] in_code,
    input  logic [LEN_W-1:0]   in_len,
    input  logic               flush_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               out_marker,
    output logic               flush_done,
    output logic               busy
);

    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] ACC_W_C  = CNT_W'(ACC_W);
    localparam logic [CNT_W-1:0] IN_LIMIT = CNT_W'(ACC_W - MAX_LEN);
    localparam logic [CNT_W-1:0] BYTE_C   = CNT_W'(8);
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

`ifdef JPEG_PACKER_EOI_EN
    localparam packer_state_t FLUSH_END = ST_EOI_FF;
`else
    localparam packer_state_t FLUSH_END = ST_DONE;
`endif

    packer_state_t    state;
    logic [ACC_W-1:0] acc, acc_mid, acc_next, app_val;
    logic [CNT_W-1:0] cnt, cnt_mid, cnt_next, app_len, shift;
    logic [LEN_W-1:0] len_eff;
    logic             accept, acc_load, marker_phase;
    logic             load_req, load_ack, load_marker;
    logic [7:0]       load_data;
    logic             stuff_set, stuff_pend, stuffer_idle;

    assign len_eff    = (in_len > MAX_LEN_C) ? MAX_LEN_C : in_len;
    assign in_ready   = (state == ST_RUN) && (cnt <= IN_LIMIT);
    assign accept     = in_valid && in_ready;
    assign busy       = (cnt != '0) || (state != ST_RUN);
    assign flush_done = (state == ST_DONE);

`ifdef JPEG_PACKER_EOI_EN
    logic d9_loaded;
    assign marker_phase = (state == ST_EOI_FF) || ((state == ST_EOI_D9) && !d9_loaded);
`else
    assign marker_phase = 1'b0;
`endif

    assign load_req    = marker_phase || (cnt >= BYTE_C);
    assign load_marker = marker_phase;
    assign load_data   = !marker_phase ? acc[ACC_W-1 -: 8] :
                         (state == ST_EOI_FF) ? MARKER_PREFIX : EOI_CODE;
    assign acc_load    = load_ack && !marker_phase;

    // Valid bits are kept left-aligned; a byte is removed from the top before
    // the new bits (code or pad ones) are appended below the remaining ones.
    always_comb begin
        cnt_mid = acc_load ? cnt - BYTE_C : cnt;
        acc_mid = acc_load ? acc << 8 : acc;
        app_val = '0;
        app_len = '0;
        if (accept) begin
            app_len = CNT_W'(len_eff);
            app_val = ACC_W'(in_code) & ((ACC_W'(1) << len_eff) - ACC_W'(1));
        end else if (state == ST_PAD) begin
            app_len = CNT_W'(pad_count(cnt[2:0]));
            app_val = (ACC_W'(1) << app_len) - ACC_W'(1);
        end
        shift    = ACC_W_C - cnt_mid - app_len;
        acc_next = acc_mid | (app_val << shift);
        cnt_next = cnt_mid + app_len;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
            acc   <= '0;
            cnt   <= '0;
`ifdef JPEG_PACKER_EOI_EN
            d9_loaded <= 1'b0;
`endif
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
            case (state)
                ST_RUN: begin
                    if (flush_req) begin
                        if (cnt_next == '0 && stuffer_idle && !load_ack)
                            state <= FLUSH_END;
                        else if (cnt_next[2:0] != 3'd0)
                            state <= ST_PAD;
                        else
                            state <= ST_DRAIN;
                    end else if (stuff_set) begin
                        state <= ST_STUFF;
                    end
                end
                ST_STUFF: if (!stuff_pend) state <= ST_RUN;
                ST_PAD:   state <= ST_DRAIN;
                ST_DRAIN: if (cnt == '0 && stuffer_idle) state <= FLUSH_END;
`ifdef JPEG_PACKER_EOI_EN
                ST_EOI_FF: begin
                    if (load_ack) begin
                        state     <= ST_EOI_D9;
                        d9_loaded <= 1'b0;
                    end
                end
                ST_EOI_D9: begin
                    if (!d9_loaded) begin
                        if (load_ack) d9_loaded <= 1'b1;
                    end else if (out_valid && out_ready) begin
                        state <= ST_DONE;
                    end
                end
`endif
                ST_DONE:  state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    jpeg_byte_stuffer u_stuffer (
        .clock       (clock),
        .reset       (reset),
        .load_req    (load_req),
        .load_data   (load_data),
        .load_marker (load_marker),
        .load_ack    (load_ack),
        .stuff_set   (stuff_set),
        .stuff_pend  (stuff_pend),
        .idle        (stuffer_idle),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_marker  (out_marker)
    );

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Self-checking bench for jpeg_bit_packer: bit-queue reference model plus
// directed literal cases and randomized traffic.
module tb_jpeg_bit_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_code;
    logic [4:0]  in_len;
    logic        flush_req;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_marker;
    logic        flush_done;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int pending_flush = 0;
    int total_done = 0;

    bit         bitq[$];
    logic [8:0] expq[$];
    logic [7:0] got[$];
    logic       hold_pend = 1'b0;
    logic [7:0] held;

    always #5 clock = ~clock;

    jpeg_bit_packer #(.ACC_W(32), .MAX_LEN(16), .LEN_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_len     (in_len),
        .flush_req  (flush_req),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_marker (out_marker),
        .flush_done (flush_done),
        .busy       (busy)
    );

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    function automatic void model_emit();
        logic [7:0] b;
        while (bitq.size() >= 8) begin
            b = '0;
            for (int i = 0; i < 8; i++) b = {b[6:0], bitq.pop_front()};
            expq.push_back({1'b0, b});
            if (b == 8'hFF) expq.push_back({1'b0, 8'h00});
        end
    endfunction

    function automatic void model_beat(input logic [15:0] code, input int len);
        for (int i = len - 1; i >= 0; i--) bitq.push_back(code[i]);
        model_emit();
    endfunction

    function automatic void model_flush();
        while (bitq.size() % 8 != 0) bitq.push_back(1'b1);
        model_emit();
`ifdef JPEG_PACKER_EOI_EN
        expq.push_back({1'b1, 8'hFF});
        expq.push_back({1'b1, 8'hD9});
`endif
        pending_flush++;
    endfunction

    // Compare process: output stream, hold stability and flush completion.
    always @(negedge clock) begin
        logic [8:0] e;
        if (!reset) begin
            if (hold_pend) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", {24'd0, out_data}, {24'd0, held});
            end
            hold_pend = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_byte: actual=%0h required=none", out_data);
                end else begin
                    e = expq.pop_front();
                    check("out_byte", {23'd0, out_marker, out_data}, {23'd0, e});
                end
            end
            if (in_valid && in_ready)
                model_beat(in_code, (in_len > 5'd16) ? 16 : int'(in_len));
            if (flush_req && in_ready) model_flush();
            if (flush_done) begin
                total_done++;
                check("done_expected", {31'd0, pending_flush > 0}, 32'd1);
                check("done_drained", expq.size(), 32'd0);
                if (pending_flush > 0) pending_flush--;
            end
        end
    end

    task automatic check_log(input string nm, input logic [7:0] e[$]);
        check({nm, "_count"}, got.size(), e.size());
        for (int i = 0; i < e.size() && i < got.size(); i++)
            check(nm, {24'd0, got[i]}, {24'd0, e[i]});
    endtask

    task automatic send(input logic [15:0] c, input logic [4:0] l);
        int n = 0;
        @(posedge clock); #1;
        in_valid = 1'b1; in_code = c; in_len = l;
        do begin @(negedge clock); n++; end while (!in_ready && n < 200);
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout: actual=stalled required=accepted");
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 500) begin
            @(negedge clock);
            n++;
            quiet = (!busy && !out_valid) ? quiet + 1 : 0;
        end
        if (quiet < 3) begin
            checks++; failures++;
            $display("FAIL idle_timeout: actual=busy required=idle");
        end
    endtask

    task automatic do_flush(input bit with_beat, input logic [15:0] c, input logic [4:0] l);
        int n = 0;
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        flush_req = 1'b1;
        if (with_beat) begin
            in_valid = 1'b1; in_code = c; in_len = l;
        end
        @(negedge clock);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
        flush_req = 1'b0;
        in_valid = 1'b0;
        while (pending_flush != 0 && n < 1000) begin @(negedge clock); n++; end
        if (pending_flush != 0) begin
            checks++; failures++;
            $display("FAIL flush_timeout: actual=pending required=done");
        end
        @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e[$];
        int n_acc;
        logic acc_now;

        reset = 1'b1; in_valid = 1'b0; in_code = '0; in_len = '0;
        flush_req = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_marker", {31'd0, out_marker}, 32'd0);
        check("rst_flush_done", {31'd0, flush_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // 1: 101 + 11110 -> 0xBE
        got.delete();
        send(16'h0005, 5'd3);
        send(16'h001E, 5'd5);
        wait_idle();
        e = {8'hBE};
        check_log("t1_bytes", e);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // 2: 0xFF is followed by a stuffed 0x00
        got.delete();
        send(16'h00FF, 5'd8);
        send(16'h0012, 5'd8);
        wait_idle();
        e = {8'hFF, 8'h00, 8'h12};
        check_log("t2_bytes", e);

        // 3: 010 then flush -> 010 11111
        got.delete();
        send(16'h0002, 5'd3);
        do_flush(1'b0, 16'h0, 5'd0);
`ifdef JPEG_PACKER_EOI_EN
        e = {8'h5F, 8'hFF, 8'hD9};
`else
        e = {8'h5F};
`endif
        check_log("t3_bytes", e);
        check("t3_done_count", total_done, 32'd1);

        // 4: backpressure fills the accumulator
        got.delete();
        @(posedge clock); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 16'hAAAA; in_len = 5'd16;
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (in_ready) n_acc++;
            @(posedge clock); #1;
        end
        check("t4_accepted_stalled", n_acc, 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 50 && n_acc < 3; i++) begin
            @(negedge clock);
            if (in_ready) n_acc++;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        check("t4_accepted_total", n_acc, 32'd3);
        wait_idle();
        e = {8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
        check_log("t4_bytes", e);

        // 5: reset mid-stream drops everything
        out_ready = 1'b0;
        send(16'h0ABC, 5'd12);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("t5_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        bitq.delete(); expq.delete(); got.delete();
        hold_pend = 1'b0; pending_flush = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        send(16'h0034, 5'd8);
        wait_idle();
        e = {8'h34};
        check_log("t5_bytes", e);

        // 6: zero length and over-length beats
        got.delete();
        send(16'h0001, 5'd0);
        repeat (3) @(posedge clock);
        check("t6_len0_busy", {31'd0, busy}, 32'd0);
        send(16'h000F, 5'd20);
        send(16'h0000, 5'd0);
        do_flush(1'b0, 16'h0, 5'd0);
`ifdef JPEG_PACKER_EOI_EN
        e = {8'h00, 8'h0F, 8'hFF, 8'hD9};
`else
        e = {8'h00, 8'h0F};
`endif
        check_log("t6_bytes", e);

        // Randomized traffic with periodic flushes
        for (int r = 0; r < 4; r++) begin
            for (int cyc = 0; cyc < 600; cyc++) begin
                @(negedge clock);
                acc_now = in_valid && in_ready;
                @(posedge clock); #1;
                if (!in_valid || acc_now) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_code  = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
                    in_len   = 5'($urandom_range(0, 20));
                end
                out_ready = (r == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            end
            for (int k = 0; k < 200 && in_valid; k++) begin
                @(negedge clock);
                acc_now = in_valid && in_ready;
                @(posedge clock); #1;
                out_ready = 1'b1;
                if (acc_now) in_valid = 1'b0;
            end
            if (in_valid) begin
                checks++; failures++;
                $display("FAIL rand_drain: actual=stalled required=accepted");
                in_valid = 1'b0;
            end
            do_flush(r[0], 16'($urandom), 5'($urandom_range(0, 20)));
        end

        wait_idle();
        check("end_exp_empty", expq.size(), 32'd0);
        check("end_bits_empty", bitq.size(), 32'd0);
        check("end_done_count", total_done, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
